// File: rtl/or_event_pkg.sv
// Shared definitions for the event aggregator: edge-mode encodings and
// the index-width helper used for pend_idx sizing.
package or_event_pkg;

  localparam int EDGE_LEVEL = 0;
  localparam int EDGE_RISE  = 1;

  // Index width for a w-entry vector; never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/or_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest 1 in vec_i, 0 when
// vec_i is all zero; valid_o flags that at least one bit is set.
module or_prio_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/or_event_aggregator.sv
// WIDTH-channel event aggregator: sticky per-channel capture (level or
// rising edge), write-1-to-clear, masking, an aggregated any flag with a
// one-cycle rise pulse, and a lowest-pending-channel index.
// Optional input synchroniser: define OR_EVENT_AGGREGATOR_SYNC_EN.
module or_event_aggregator
  import or_event_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  EDGE_MODE = EDGE_LEVEL,
  parameter int  OUT_REG   = 1,
  localparam int IDX_W     = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ev_in,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] clr,
  input  logic             clr_all,
  output logic [WIDTH-1:0] status,
  output logic             any,
  output logic             any_rise,
  output logic [IDX_W-1:0] pend_idx,
  output logic             pend_valid
);

  logic [WIDTH-1:0] ev_s;
  logic [WIDTH-1:0] ev_prev_q;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] masked;
  logic [IDX_W-1:0] idx_c, idx_q;
  logic             valid_c;
  logic             any_q;
  logic             any_rise_q;

`ifdef OR_EVENT_AGGREGATOR_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Two-flop synchroniser per channel for sources outside the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ev_in;
      sync2_q <= sync1_q;
    end
  end

  assign ev_s = sync2_q;
`else
  assign ev_s = ev_in;
`endif

  // Edge history; reset to 0 so a line already high at release counts once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ev_prev_q <= '0;
    else        ev_prev_q <= ev_s;
  end

  assign set_vec = (EDGE_MODE == EDGE_RISE) ? (ev_s & ~ev_prev_q) : ev_s;

  // Clear first, then OR in new events so a same-cycle event survives a clear.
  always_comb begin
    status_d = (status_q & ~(clr | {WIDTH{clr_all}})) | set_vec;
  end

  // Sticky status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= '0;
    else        status_q <= status_d;
  end

  assign masked = status_q & mask;

  or_prio_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec_i   (masked),
    .idx_o   (idx_c),
    .valid_o (valid_c)
  );

  // Registered view of the aggregate; any_q doubles as the history for the
  // rise detector, so the pulse lines up with the registered any.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q      <= 1'b0;
      idx_q      <= '0;
      any_rise_q <= 1'b0;
    end else begin
      any_q      <= valid_c;
      idx_q      <= idx_c;
      any_rise_q <= valid_c & ~any_q;
    end
  end

  assign status     = status_q;
  assign any        = (OUT_REG != 0) ? any_q : valid_c;
  assign pend_valid = any;
  assign pend_idx   = (OUT_REG != 0) ? idx_q : idx_c;
  assign any_rise   = any_rise_q;

endmodule

// File: tb/tb_or_event_aggregator.sv
// Directed bench: three instances sharing stimulus -- level/registered,
// rise-edge/registered, and level/combinational outputs.
module tb_or_event_aggregator;

`ifdef OR_EVENT_AGGREGATOR_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] ev_in, mask, clr;
  logic       clr_all;

  logic [7:0] l_status, e_status, c_status;
  logic       l_any, e_any, c_any;
  logic       l_rise, e_rise, c_rise;
  logic [2:0] l_idx, e_idx, c_idx;
  logic       l_valid, e_valid, c_valid;

  int total = 0;
  int bad   = 0;

  or_event_aggregator #(.WIDTH(8), .EDGE_MODE(0), .OUT_REG(1)) u_lvl (
    .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .mask(mask), .clr(clr),
    .clr_all(clr_all), .status(l_status), .any(l_any), .any_rise(l_rise),
    .pend_idx(l_idx), .pend_valid(l_valid));

  or_event_aggregator #(.WIDTH(8), .EDGE_MODE(1), .OUT_REG(1)) u_edg (
    .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .mask(mask), .clr(clr),
    .clr_all(clr_all), .status(e_status), .any(e_any), .any_rise(e_rise),
    .pend_idx(e_idx), .pend_valid(e_valid));

  or_event_aggregator #(.WIDTH(8), .EDGE_MODE(0), .OUT_REG(0)) u_cmb (
    .clk(clk), .rst_n(rst_n), .ev_in(ev_in), .mask(mask), .clr(clr),
    .clr_all(clr_all), .status(c_status), .any(c_any), .any_rise(c_rise),
    .pend_idx(c_idx), .pend_valid(c_valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cleanup();
    ev_in = 8'h00; clr = 8'h00; clr_all = 1'b1;
    repeat (SL + 3) tick();
    clr_all = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ev_in = 8'h00; mask = 8'hFF; clr = 8'h00; clr_all = 1'b0;
    #3;
    total++; if (l_status !== 8'h00) begin bad++; $display("FAIL reset_status got=%h exp=00", l_status); end
    total++; if (l_any !== 1'b0 || l_rise !== 1'b0 || l_valid !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b%b exp=000", l_any, l_rise, l_valid); end
    total++; if (l_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", l_idx); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (l_status !== 8'h00 || l_any !== 1'b0) begin bad++; $display("FAIL idle_c%0d status=%h any=%b exp=00/0", c, l_status, l_any); end
    end
  endtask

  task automatic test_level_capture();
    ev_in = 8'h08;
    tick();
    ev_in = 8'h00;
    repeat (SL) tick();
    total++; if (l_status !== 8'h08) begin bad++; $display("FAIL lvl_status got=%h exp=08", l_status); end
    total++; if (l_any !== 1'b0) begin bad++; $display("FAIL lvl_any_lat got=%b exp=0", l_any); end
    total++; if (c_any !== 1'b1 || c_idx !== 3'd3) begin bad++; $display("FAIL cmb_any_idx got=%b/%0d exp=1/3", c_any, c_idx); end
    tick();
    total++; if (l_any !== 1'b1 || l_valid !== 1'b1) begin bad++; $display("FAIL lvl_any got=%b/%b exp=1/1", l_any, l_valid); end
    total++; if (l_idx !== 3'd3) begin bad++; $display("FAIL lvl_idx got=%0d exp=3", l_idx); end
    total++; if (l_rise !== 1'b1) begin bad++; $display("FAIL lvl_rise got=%b exp=1", l_rise); end
    total++; if (c_rise !== 1'b1) begin bad++; $display("FAIL cmb_rise got=%b exp=1", c_rise); end
    tick();
    total++; if (l_rise !== 1'b0 || l_any !== 1'b1) begin bad++; $display("FAIL lvl_rise_once got=%b any=%b exp=0/1", l_rise, l_any); end
  endtask

  task automatic test_sticky_clear();
    ev_in = 8'h20;
    tick();
    ev_in = 8'h00;
    repeat (SL) tick();
    total++; if (l_status !== 8'h28) begin bad++; $display("FAIL sticky_status got=%h exp=28", l_status); end
    tick();
    total++; if (l_idx !== 3'd3 || l_rise !== 1'b0) begin bad++; $display("FAIL sticky_idx got=%0d rise=%b exp=3/0", l_idx, l_rise); end
    clr = 8'h08;
    tick();
    clr = 8'h00;
    total++; if (l_status !== 8'h20) begin bad++; $display("FAIL clr_status got=%h exp=20", l_status); end
    tick();
    total++; if (l_idx !== 3'd5 || l_any !== 1'b1 || l_rise !== 1'b0) begin bad++; $display("FAIL clr_idx got=%0d any=%b rise=%b exp=5/1/0", l_idx, l_any, l_rise); end
    clr = 8'h01;
    tick();
    clr = 8'h00;
    total++; if (l_status !== 8'h20) begin bad++; $display("FAIL clr_zero_bit got=%h exp=20", l_status); end
    clr_all = 1'b1; clr = 8'hFF;
    tick();
    clr_all = 1'b0; clr = 8'h00;
    total++; if (l_status !== 8'h00) begin bad++; $display("FAIL clr_all_status got=%h exp=00", l_status); end
    tick();
    total++; if (l_any !== 1'b0 || l_valid !== 1'b0) begin bad++; $display("FAIL clr_all_any got=%b exp=0", l_any); end
  endtask

  task automatic test_set_beats_clear();
    ev_in = 8'h04;
    repeat (SL) tick();
    clr = 8'h04;
    tick();
    ev_in = 8'h00; clr = 8'h00;
    total++; if (l_status[2] !== 1'b1) begin bad++; $display("FAIL set_vs_clr got=%b exp=1", l_status[2]); end
    cleanup();
  endtask

  task automatic test_all_pending();
    ev_in = 8'hFF;
    tick();
    ev_in = 8'h00;
    repeat (SL) tick();
    tick();
    total++; if (l_idx !== 3'd0 || l_any !== 1'b1) begin bad++; $display("FAIL all_pending got=%0d any=%b exp=0/1", l_idx, l_any); end
    cleanup();
  endtask

  task automatic test_edge_mode();
    logic exp;
    ev_in = 8'h01;
    for (int c = 1; c <= 10; c++) begin
      clr = (c == 4) ? 8'h01 : 8'h00;
      tick();
      exp = (c >= 1 + SL) && (c < 4);
      total++; if (e_status[0] !== exp) begin bad++; $display("FAIL edge_hold_c%0d got=%b exp=%b", c, e_status[0], exp); end
    end
    clr = 8'h00;
    total++; if (l_status[0] !== 1'b1) begin bad++; $display("FAIL lvl_recapture got=%b exp=1", l_status[0]); end
    ev_in = 8'h00;
    repeat (SL + 2) tick();
    total++; if (e_status[0] !== 1'b0) begin bad++; $display("FAIL edge_fall got=%b exp=0", e_status[0]); end
    ev_in = 8'h01;
    tick();
    repeat (SL) tick();
    total++; if (e_status[0] !== 1'b1) begin bad++; $display("FAIL edge_new_rise got=%b exp=1", e_status[0]); end
    cleanup();
  endtask

  task automatic test_mask_prio();
    mask = 8'h80; ev_in = 8'h81;
    tick();
    ev_in = 8'h00;
    repeat (SL) tick();
    total++; if (c_any !== 1'b1 || c_idx !== 3'd7) begin bad++; $display("FAIL mask80_cmb got=%b/%0d exp=1/7", c_any, c_idx); end
    tick();
    total++; if (l_any !== 1'b1 || l_idx !== 3'd7) begin bad++; $display("FAIL mask80_lvl got=%b/%0d exp=1/7", l_any, l_idx); end
    tick();
    mask = 8'h00;
    #1;
    total++; if (c_any !== 1'b0 || c_valid !== 1'b0) begin bad++; $display("FAIL mask00_cmb got=%b exp=0", c_any); end
    tick();
    total++; if (l_any !== 1'b0 || l_status !== 8'h81) begin bad++; $display("FAIL mask00_lvl any=%b status=%h exp=0/81", l_any, l_status); end
    mask = 8'hFF;
    tick();
    total++; if (l_any !== 1'b1 || l_idx !== 3'd0 || l_rise !== 1'b1) begin bad++; $display("FAIL unmask any=%b idx=%0d rise=%b exp=1/0/1", l_any, l_idx, l_rise); end
    tick();
    total++; if (l_rise !== 1'b0) begin bad++; $display("FAIL unmask_rise_once got=%b exp=0", l_rise); end
    cleanup();
  endtask

  task automatic test_reset_mid();
    ev_in = 8'hFF;
    tick();
    ev_in = 8'h00;
    repeat (SL) tick();
    tick();
    total++; if (l_status !== 8'hFF || l_any !== 1'b1) begin bad++; $display("FAIL pre_rst status=%h any=%b exp=ff/1", l_status, l_any); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (l_status !== 8'h00 || e_status !== 8'h00 || c_status !== 8'h00) begin bad++; $display("FAIL async_rst_status got=%h/%h/%h exp=00", l_status, e_status, c_status); end
    total++; if (l_any !== 1'b0 || l_valid !== 1'b0 || l_idx !== 3'd0 || c_any !== 1'b0) begin bad++; $display("FAIL async_rst_out any=%b valid=%b idx=%0d cany=%b exp=0", l_any, l_valid, l_idx, c_any); end
    tick();
    ev_in = 8'h01;
    tick();
    rst_n = 1'b1;
    ev_in = 8'h00;
    for (int c = 0; c < SL + 3; c++) begin
      tick();
      total++; if (l_status !== 8'h00 || e_status !== 8'h00 || l_rise !== 1'b0) begin bad++; $display("FAIL post_rst_c%0d status=%h/%h rise=%b exp=00/00/0", c, l_status, e_status, l_rise); end
    end
  endtask

  initial begin
    test_reset();
    test_level_capture();
    test_sticky_clear();
    test_set_beats_clear();
    test_all_pending();
    test_edge_mode();
    test_mask_prio();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/or_event_aggregator.md
Name: or_event_aggregator

Overview:
- Parametrised successor to the team's 2-input OR primitive: a WIDTH-channel OR-reduction with sticky per-channel capture, masking and write-1-to-clear.
- Collects asynchronous-to-logic event lines (level or rising-edge qualified) into a status register.
- Drives one aggregated "any" flag plus a lowest-pending-channel index.
- Sits between peripheral event sources and the interrupt/controller logic.

Parameters:
- WIDTH, 8, number of event channels (2..64).
- EDGE_MODE, 0, 0 = capture while input high (level); 1 = capture on 0->1 transition only.
- OUT_REG, 1, 1 = any/pend_idx/pend_valid registered (+1 cycle); 0 = combinational from status.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ev_in  input  WIDTH  raw event lines.
- mask  input  WIDTH  1 = channel enabled into any/pend_idx (status still captures).
- clr  input  WIDTH  write-1-to-clear pulse per channel.
- clr_all  input  1  clears every status bit.
- status  output  WIDTH  sticky captured events.
- any  output  1  OR of (status & mask).
- any_rise  output  1  one-cycle pulse when any goes 0->1.
- pend_idx  output  $clog2(WIDTH)  lowest set index of (status & mask); 0 when none.
- pend_valid  output  1  equals any.

Behaviour:
- Reset (rst_n low, asynchronous): status, edge-history register, any, any_rise, pend_idx, pend_valid all 0. Release is synchronous to clk for logic purposes.
- set_vec:
  - EDGE_MODE=0: set_vec = ev_in.
  - EDGE_MODE=1: set_vec = ev_in & ~ev_prev, where ev_prev is a register of ev_in, reset 0. An input already high at reset release therefore counts as one edge.
- Status update each cycle: status <= (status & ~(clr | {WIDTH{clr_all}})) | set_vec.
  - Set has priority over clear in the same cycle, so no event is lost.
- Latency, OUT_REG=1:
  - ev_in sampled at edge n appears in status after edge n.
  - any and pend_idx update after edge n+1.
- Latency, OUT_REG=0: any and pend_idx follow status combinationally, in the same cycle as status.
- any_rise: registered, 1 for exactly one cycle after any transitions 0->1. No pulse while any stays high, even if further channels set.
- Mask:
  - A change in mask affects any and pend_idx with the same latency as a status change.
  - Masking a set channel keeps its status bit.
  - Unmasking a set channel raises any (and any_rise if any was 0).
- pend_idx: fixed priority, lowest index wins.
  - All channels pending -> 0.
  - Only channel WIDTH-1 pending -> WIDTH-1.
- clr on a bit that is already 0 has no effect. clr_all with clr is the same as clr_all.
- Reset asserted mid-operation: all state clears immediately. Pending events are dropped; no any_rise on release unless new events arrive.

Optional Feature:
- Macro: OR_EVENT_AGGREGATOR_SYNC_EN.
- Defined:
  - ev_in passes through a 2-flop synchroniser per bit (reset 0) before edge detection and capture.
  - Capture latency grows by 2 cycles.
  - In EDGE_MODE=1, ev_prev samples the synchronised signal.
- Undefined: ev_in is used directly. Sources must already be synchronous to clk.

Decomposition:
- Shared package or_event_pkg:
  - localparam function for index width (clog2 with minimum 1).
  - EDGE_MODE encodings LEVEL=0, RISE=1.
- One natural sub-module: or_prio_enc, a parametrised WIDTH-to-index lowest-set-bit encoder with valid output. It is combinational and instantiated once for pend_idx/pend_valid.

Test Plan:
- Reset and level capture: WIDTH=8, EDGE_MODE=0, OUT_REG=1, mask=8'hFF. Reset, then ev_in=8'h00 for 5 cycles -> status=0, any=0. Pulse ev_in[3] for 1 cycle -> status=8'h08 next cycle, any=1 and pend_idx=3 one cycle later, any_rise a single pulse.
- Sticky and clear: with status=8'h28, pulse clr=8'h08 -> status=8'h20, pend_idx=5, no new any_rise. Then clr_all -> status=0, any=0.
- Set beats clear: ev_in[2]=1 and clr[2]=1 in the same cycle -> status[2]=1 afterwards.
- Edge mode: EDGE_MODE=1. Hold ev_in[0] high for 10 cycles -> status[0] sets once. clr[0] at cycle 4 -> stays 0 while the input remains high. A new 0->1 transition sets it again.
- Mask and priority: status=8'h81, mask=8'h80 -> any=1, pend_idx=7. Change mask to 8'h00 -> any=0, status unchanged. Change mask to 8'hFF -> pend_idx=0, any_rise pulses.
- Reset mid-operation: status=8'hFF, drop rst_n asynchronously between clock edges -> all outputs 0 immediately. With the sync macro defined, an event presented 1 cycle before release is not captured.
